// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FIFO geometry and default flag thresholds
package fifo_ctrl_pkg;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_WIDTH = 3;
  localparam int FIFO_AF_DEFAULT = 6;
  localparam int FIFO_AE_DEFAULT = 2;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: enable-gated modulo-DEPTH pointer counter
module fifo_ptr_cnt
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [PTR_WIDTH-1:0] ptr
);
  always_ff @(posedge clk)
    if (!reset) ptr <= '0;
    else if (en) ptr <= (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO pointer, occupancy, flag and error control
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PTR_WIDTH:0]   af_thresh,
  input  logic [PTR_WIDTH:0]   ae_thresh,
  output logic                 wr_enable,
  output logic                 rd_enable,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH-1:0] rd_ptr,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);
  always_comb begin
    full = count == (PTR_WIDTH + 1)'(DEPTH);
    empty = count == '0;
    almost_full = count >= af_thresh;
    almost_empty = count <= ae_thresh;
    rd_enable = reset & pop & ~empty;
    wr_enable = reset & push & (~full | rd_enable);
  end
  fifo_ptr_cnt #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_wr (
    .clk(clk), .reset(reset), .en(wr_enable), .ptr(wr_ptr)
  );
  fifo_ptr_cnt #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_rd (
    .clk(clk), .reset(reset), .en(rd_enable), .ptr(rd_ptr)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      count <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count <= (wr_enable & ~rd_enable) ? count + 1'b1 :
               (rd_enable & ~wr_enable) ? count - 1'b1 : count;
      overflow_err <= overflow_err | (push & full & ~pop);
      underflow_err <= underflow_err | (pop & empty);
    end
endmodule
